// File: rtl/uart_cmd_rx_if.sv
// Receive-side bus of the UART command receiver: serial line in, byte/handshake
// and command latch out.
interface uart_cmd_rx_if;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       pwr_up;

  // Driver of the serial line and consumer of received bytes.
  modport master (
    output RX, clr_rdy,
    input  rx_data, rdy, frm_err, pwr_up
  );

  // The receiver itself.
  modport slave (
    input  RX, clr_rdy,
    output rx_data, rdy, frm_err, pwr_up
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with ready/clear handshake, framing-error flag and a
// go/stop command latch driving pwr_up.
module uart_cmd_rx #(
  parameter int         BAUD_DIV = 2604,
  parameter logic [7:0] CMD_GO   = 8'h47,
  parameter logic [7:0] CMD_STOP = 8'h53
) (
  input  logic         clk,
  input  logic         rst,
  uart_cmd_rx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int CW = $clog2(BAUD_DIV);
  // The counter is loaded one edge after start detect and acts one edge after
  // reaching zero, hence the -2 / -1 offsets that land samples on the
  // BAUD_DIV/2 + k*BAUD_DIV edges after the synchronized falling edge.
  localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV/2 - 2);
  localparam logic [CW-1:0] FULL_LD = CW'(BAUD_DIV - 1);

  state_t        state, nstate;
  logic          rx_ff1, rx_ff2, rx_prev;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  logic start_det, expire;
  logic ld_half, go_data, shift_en, frame_ok, frame_bad;

  assign start_det = rx_prev & ~rx_ff2;
  assign expire    = (baud_cnt == '0);

  // Two-flop synchronizer plus a history flop; all reset to 0 so a line held
  // low through reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ff1  <= 1'b0;
      rx_ff2  <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_ff1  <= bus.RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (start_det) nstate = START;
      START: if (expire)    nstate = rx_ff2 ? IDLE : DATA;
      DATA:  if (expire && bit_cnt == 3'd7) nstate = STOP;
      STOP:  if (expire)    nstate = IDLE;
      default:              nstate = IDLE;
    endcase
  end

  // Datapath control strobes decoded from the state.
  always_comb begin
    ld_half   = (state == IDLE)  && start_det;
    go_data   = (state == START) && expire && !rx_ff2;
    shift_en  = (state == DATA)  && expire;
    frame_ok  = (state == STOP)  && expire && rx_ff2;
    frame_bad = (state == STOP)  && expire && !rx_ff2;
  end

  // Bit timer, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      if (ld_half)                baud_cnt <= HALF_LD;
      else if (go_data || shift_en) baud_cnt <= FULL_LD;
      else if (!expire)           baud_cnt <= baud_cnt - 1'b1;

      if (go_data)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;

      if (shift_en) shreg <= {rx_ff2, shreg[7:1]};
    end
  end

  // Output registers: byte/handshake, framing flag and command latch.
  // A valid stop bit wins over a same-cycle clr_rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rx_data <= 8'h00;
      bus.rdy     <= 1'b0;
      bus.frm_err <= 1'b0;
      bus.pwr_up  <= 1'b0;
    end else begin
      if (frame_ok)                   bus.rdy <= 1'b1;
      else if (ld_half || bus.clr_rdy) bus.rdy <= 1'b0;

      if (frame_ok) begin
        bus.rx_data <= shreg;
        bus.frm_err <= 1'b0;
        if (shreg == CMD_GO)        bus.pwr_up <= 1'b1;
        else if (shreg == CMD_STOP) bus.pwr_up <= 1'b0;
      end else if (frame_bad) begin
        bus.frm_err <= 1'b1;
      end
    end
  end

endmodule
